cdot_sequencer: RTL and testbench
=================================

Name: cdot_sequencer

Overview:
- Sequences one complex dot product of length N through the shared complex-multiply datapath: operand memories, then the four real multipliers, then the subtract/add stage producing ab_real/ab_imag.
- Issues element indices, tracks in-flight products with a valid pipeline, and accumulates the Q11.21 real/imag results into guarded accumulators.
- Signals completion with a one-cycle done pulse.
- Sits between the matrix-level controller (start/abort) and the datapath.

Parameters:
- N, 32, number of element pairs per dot product (2..2^IDX_W).
- IDX_W, 5, width of addr.
- PIPE_LAT, 2, cycles from addr/addr_vld presented to the matching ab_real/ab_imag being valid at this block's inputs (>=1).
- GUARD, 5, extra integer bits in the accumulators. GUARD >= ceil(log2 N) means no overflow.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a dot product; sampled only in IDLE or DONE
- abort  in  1  synchronous cancel; wins over start
- addr  out  IDX_W  element index to operand memories
- addr_vld  out  1  addr is a valid issue this cycle
- ab_real  in  32  signed Q11.21 ([10:-21]) real product
- ab_imag  in  32  signed Q11.21 imaginary product
- acc_real  out  32+GUARD  signed Q(11+GUARD).21 accumulated real part
- acc_imag  out  32+GUARD  signed Q(11+GUARD).21 accumulated imaginary part
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; acc_* final

Behaviour:
- Reset (rst=0, async): state=IDLE; addr=0, addr_vld=0, busy=0, done=0, acc_real=0, acc_imag=0; valid pipeline cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - busy=0, addr_vld=0.
  - start=1 & abort=0 at edge E: go to ISSUE, clear acc_*, addr=0.
- ISSUE:
  - busy=1, addr_vld=1; addr = 0,1,...,N-1 in consecutive cycles following edges E..E+N-1.
  - After addr=N-1 is issued, go to DRAIN; addr_vld=0, addr holds N-1.
- Valid tracking: a PIPE_LAT-deep shift register carries addr_vld. At each edge where its output tap=1: acc_real += sext(ab_real), acc_imag += sext(ab_imag). Two's-complement add, wraps if GUARD is insufficient; no saturation.
- DRAIN:
  - busy=1.
  - Once the last product has been accumulated (edge E+N+PIPE_LAT), go to DONE.
- DONE:
  - One cycle: done=1, busy=1; acc_* final and held until the next accepted start or reset.
  - start=1 in DONE: go directly to ISSUE (back-to-back), acc_* cleared at that edge.
  - Otherwise go to IDLE.
- Latency: done is high in the cycle after edge E+N+PIPE_LAT (N=32, L=2: 34 edges after start sampled). Throughput: one element per cycle, no bubbles.
- start while in ISSUE/DRAIN: ignored, no effect.
- abort=1 in any state:
  - Next state IDLE; addr_vld=0, addr=0, valid pipeline flushed.
  - acc_* cleared, done stays 0, busy=0 from the next cycle.
  - abort and start together: abort wins, stays IDLE.
- Async reset mid-operation: same as abort, immediately and without a clock edge.
- ab_* are ignored (X-tolerant) whenever the pipeline tap is 0.

Test Plan:
- Basic accumulation: N=32, L=2; ab_real=0x0020_0000 (+1.0), ab_imag=0xFFF0_0000 (-0.5) every valid cycle -> done exactly 34 edges after start; acc_real=32.0 (0x0_0400_0000), acc_imag=-16.0 (0x1F_FE00_0000); addr_vld high for exactly 32 cycles with addr 0..31.
- Index-tagged products: ab_real = k<<21 for the product of addr k (model with PIPE_LAT delay), ab_imag = -(k<<21) -> acc_real=496.0, acc_imag=-496.0; shows ordering and no dropped or duplicated element.
- Extreme negative: ab_real=ab_imag=0x8000_0000 (-1024.0) for all 32 -> acc_*=-32768.0 (0x10_0000_0000), no wrap; done pulse one cycle wide.
- Start handling: start re-asserted during ISSUE and DRAIN -> ignored, single done. Start held high in the DONE cycle -> a second run begins with no idle cycle; acc_* cleared; second done 34 edges later.
- Abort: abort at ISSUE cycle with addr=10 -> next cycle addr_vld=0, busy=0, acc_*=0; no done pulse; subsequent start runs normally from addr 0. Abort and start together in IDLE -> stays IDLE.
- Reset: rst low asynchronously mid-DRAIN -> all outputs 0 immediately; after release, no spurious done or addr_vld; PIPE_LAT=4 rerun of the basic test -> done at edge E+36.

Source files
------------

// File: rtl/cdot_sequencer_if.sv
// Handshake and data bundle between the matrix controller / complex-multiply
// datapath and the dot-product sequencer.
interface cdot_sequencer_if #(
  parameter int IDX_W = 5,
  parameter int GUARD = 5
);
  logic                  start;
  logic                  abort;
  logic [IDX_W-1:0]      addr;
  logic                  addr_vld;
  logic [31:0]           ab_real;
  logic [31:0]           ab_imag;
  logic [31+GUARD:0]     acc_real;
  logic [31+GUARD:0]     acc_imag;
  logic                  busy;
  logic                  done;

  // Controller + datapath side
  modport master (
    output start, abort, ab_real, ab_imag,
    input  addr, addr_vld, acc_real, acc_imag, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, abort, ab_real, ab_imag,
    output addr, addr_vld, acc_real, acc_imag, busy, done
  );
endinterface

// File: rtl/cdot_sequencer.sv
// Complex dot-product sequencer: issues N element indices to the operand
// memories, tracks products through the PIPE_LAT-deep datapath with a valid
// shift register, accumulates Q11.21 real/imag products into guarded
// accumulators and pulses done when the last product has been summed.
module cdot_sequencer #(
  parameter int N        = 32,
  parameter int IDX_W    = 5,
  parameter int PIPE_LAT = 2,
  parameter int GUARD    = 5
) (
  input  logic            clk,
  input  logic            rst,     // asynchronous, active low
  cdot_sequencer_if.slave io_bus
);

  localparam int ACC_W = 32 + GUARD;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N - 1);
  // Marks the output tap of the valid pipeline; everything else is "in flight".
  localparam logic [PIPE_LAT-1:0] TAP_MASK = PIPE_LAT'(1) << (PIPE_LAT - 1);

  logic [1:0]          r_state;
  logic [IDX_W-1:0]    r_addr;
  logic                r_addr_vld;
  logic                r_busy;
  logic                r_done;
  logic [PIPE_LAT-1:0] r_vld_pipe;
  logic [ACC_W-1:0]    r_acc_real;
  logic [ACC_W-1:0]    r_acc_imag;

  logic [1:0]          w_next_state;
  logic                w_accept;
  logic                w_tap;
  logic                w_in_flight_empty;
  logic [ACC_W-1:0]    w_ab_real_sx;
  logic [ACC_W-1:0]    w_ab_imag_sx;

  assign w_tap             = r_vld_pipe[PIPE_LAT-1];
  assign w_in_flight_empty = ((r_vld_pipe & ~TAP_MASK) == {PIPE_LAT{1'b0}});
  assign w_ab_real_sx      = {{GUARD{io_bus.ab_real[31]}}, io_bus.ab_real};
  assign w_ab_imag_sx      = {{GUARD{io_bus.ab_imag[31]}}, io_bus.ab_imag};

  // Next-state decode; abort overrides everything, start only counts in IDLE/DONE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    if (io_bus.abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            w_next_state = S_ISSUE;
            w_accept     = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_ISSUE: begin
          if (r_addr == LAST_IDX) begin
            w_next_state = S_DRAIN;
          end else begin
            w_next_state = S_ISSUE;
          end
        end
        S_DRAIN: begin
          // Last product sits on the tap and nothing else is behind it.
          if (w_tap && w_in_flight_empty) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_DRAIN;
          end
        end
        S_DONE: begin
          if (io_bus.start) begin
            w_next_state = S_ISSUE;
            w_accept     = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // State register and registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_addr_vld <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_busy     <= (w_next_state != S_IDLE);
      r_done     <= (w_next_state == S_DONE);
      r_addr_vld <= (w_next_state == S_ISSUE);
    end
  end

  // Element index: restarts at 0 on accept/abort, steps while issuing, else holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= {IDX_W{1'b0}};
    end else if (io_bus.abort || w_accept) begin
      r_addr <= {IDX_W{1'b0}};
    end else if ((r_state == S_ISSUE) && (w_next_state == S_ISSUE)) begin
      r_addr <= r_addr + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      r_addr <= r_addr;
    end
  end

  // Valid pipeline mirroring the datapath latency; flushed on abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= {PIPE_LAT{1'b0}};
    end else if (io_bus.abort) begin
      r_vld_pipe <= {PIPE_LAT{1'b0}};
    end else begin
      r_vld_pipe <= (r_vld_pipe << 1) | PIPE_LAT'(r_addr_vld);
    end
  end

  // Guarded accumulators: cleared on abort or a new run, add only when the tap is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_real <= {ACC_W{1'b0}};
      r_acc_imag <= {ACC_W{1'b0}};
    end else if (io_bus.abort || w_accept) begin
      r_acc_real <= {ACC_W{1'b0}};
      r_acc_imag <= {ACC_W{1'b0}};
    end else if (w_tap) begin
      r_acc_real <= r_acc_real + w_ab_real_sx;
      r_acc_imag <= r_acc_imag + w_ab_imag_sx;
    end else begin
      r_acc_real <= r_acc_real;
      r_acc_imag <= r_acc_imag;
    end
  end

  assign io_bus.addr     = r_addr;
  assign io_bus.addr_vld = r_addr_vld;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.acc_real = r_acc_real;
  assign io_bus.acc_imag = r_acc_imag;

endmodule

// File: tb/tb_cdot_sequencer.sv
// Directed bench for cdot_sequencer: two instances (PIPE_LAT=2 and 4) share
// start/abort/reset; each has a small datapath model that returns products
// PIPE_LAT cycles after the index was issued.
module tb_cdot_sequencer;

  logic clk;
  logic rst_n;
  logic start_s;
  logic abort_s;
  int   mode;
  int   n_chk;
  int   n_fail;

  cdot_sequencer_if #(.IDX_W(5), .GUARD(5)) bus2 ();
  cdot_sequencer_if #(.IDX_W(5), .GUARD(5)) bus4 ();

  cdot_sequencer #(.N(32), .IDX_W(5), .PIPE_LAT(2), .GUARD(5)) dut2 (
    .clk(clk), .rst(rst_n), .io_bus(bus2)
  );
  cdot_sequencer #(.N(32), .IDX_W(5), .PIPE_LAT(4), .GUARD(5)) dut4 (
    .clk(clk), .rst(rst_n), .io_bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus2.start = start_s;
  assign bus2.abort = abort_s;
  assign bus4.start = start_s;
  assign bus4.abort = abort_s;

  // Datapath model: {vld, idx} delayed by the pipeline latency.
  logic [5:0] dl2 [2];
  logic [5:0] dl4 [4];

  // Delay lines carrying issued indices towards the product inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) dl2[i] <= 6'd0;
      for (int i = 0; i < 4; i++) dl4[i] <= 6'd0;
    end else begin
      dl2[0] <= {bus2.addr_vld, bus2.addr};
      dl2[1] <= dl2[0];
      dl4[0] <= {bus4.addr_vld, bus4.addr};
      for (int i = 1; i < 4; i++) dl4[i] <= dl4[i-1];
    end
  end

  function automatic logic [63:0] gen(input int m, input logic [5:0] t);
    logic [31:0] kk;
    kk = 32'(t[4:0]) << 21;
    if (!t[5]) return {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    case (m)
      0:       return {32'h0020_0000, 32'hFFF0_0000};
      1:       return {kk, 32'd0 - kk};
      default: return {32'h8000_0000, 32'h8000_0000};
    endcase
  endfunction

  assign {bus2.ab_real, bus2.ab_imag} = gen(mode, dl2[1]);
  assign {bus4.ab_real, bus4.ab_imag} = gen(mode, dl4[3]);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full run from a start pulse; checks timing, indices and final sums.
  task automatic run_check(input string nm, input int m, input bit rea,
                           input logic [36:0] er, input logic [36:0] ei);
    int d2_at, d4_at, d2_cnt, d4_cnt, nvld;
    bit addr_ok;
    d2_at = -1; d4_at = -1; d2_cnt = 0; d4_cnt = 0; nvld = 0; addr_ok = 1'b1;
    mode = m;
    @(negedge clk);
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    for (int e = 0; e < 60; e++) begin
      if (bus2.addr_vld) begin
        if (bus2.addr != 5'(nvld)) addr_ok = 1'b0;
        nvld++;
      end
      if (bus2.done) begin
        d2_cnt++;
        if (d2_at < 0) begin
          d2_at = e;
          chk({nm, "_acc_real"}, 64'(bus2.acc_real), 64'(er));
          chk({nm, "_acc_imag"}, 64'(bus2.acc_imag), 64'(ei));
          chk({nm, "_busy_in_done"}, 64'(bus2.busy), 64'd1);
        end
      end
      if (bus4.done) begin
        d4_cnt++;
        if (d4_at < 0) begin
          d4_at = e;
          chk({nm, "_l4_acc_real"}, 64'(bus4.acc_real), 64'(er));
          chk({nm, "_l4_acc_imag"}, 64'(bus4.acc_imag), 64'(ei));
        end
      end
      start_s = rea && (e == 5 || e == 33);
      step();
    end
    start_s = 1'b0;
    chk({nm, "_done_edge"},    64'(d2_at),  64'd34);
    chk({nm, "_done_pulses"},  64'(d2_cnt), 64'd1);
    chk({nm, "_vld_cycles"},   64'(nvld),   64'd32);
    chk({nm, "_addr_order"},   64'(addr_ok), 64'd1);
    chk({nm, "_l4_done_edge"}, 64'(d4_at),  64'd36);
    chk({nm, "_l4_pulses"},    64'(d4_cnt), 64'd1);
    chk({nm, "_idle_after"},   64'(bus2.busy | bus4.busy), 64'd0);
  endtask

  typedef struct {
    string      nm;
    int         m;
    bit         rea;
    logic [36:0] er;
    logic [36:0] ei;
  } vec_t;

  vec_t vecs [4];

  // Watchdog: a hung run still reports before stopping.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int cnt;
    n_chk = 0; n_fail = 0;
    start_s = 1'b0; abort_s = 1'b0; mode = 0;

    vecs[0] = '{"basic",    0, 1'b0, 37'h00_0400_0000, 37'h1F_FE00_0000};
    vecs[1] = '{"tagged",   1, 1'b0, 37'h00_3E00_0000, 37'h1F_C200_0000};
    vecs[2] = '{"extreme",  2, 1'b0, 37'h10_0000_0000, 37'h10_0000_0000};
    vecs[3] = '{"restart",  0, 1'b1, 37'h00_0400_0000, 37'h1F_FE00_0000};

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy",     64'(bus2.busy),     64'd0);
    chk("rst_done",     64'(bus2.done),     64'd0);
    chk("rst_vld",      64'(bus2.addr_vld), 64'd0);
    chk("rst_addr",     64'(bus2.addr),     64'd0);
    chk("rst_acc_real", 64'(bus2.acc_real), 64'd0);
    chk("rst_acc_imag", 64'(bus2.acc_imag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven runs
    for (int i = 0; i < 4; i++) begin
      run_check(vecs[i].nm, vecs[i].m, vecs[i].rea, vecs[i].er, vecs[i].ei);
    end

    // Back-to-back: start held in the DONE cycle
    mode = 0;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    found = 1'b0;
    for (int e = 0; e < 60 && !found; e++) begin
      if (bus2.done) found = 1'b1;
      else step();
    end
    chk("b2b_first_done", 64'(found), 64'd1);
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    chk("b2b_vld",      64'(bus2.addr_vld), 64'd1);
    chk("b2b_addr",     64'(bus2.addr),     64'd0);
    chk("b2b_busy",     64'(bus2.busy),     64'd1);
    chk("b2b_acc_real", 64'(bus2.acc_real), 64'd0);
    chk("b2b_acc_imag", 64'(bus2.acc_imag), 64'd0);
    cnt = -1;
    for (int e = 0; e < 60 && cnt < 0; e++) begin
      if (bus2.done) cnt = e;
      else step();
    end
    chk("b2b_second_edge", 64'(cnt), 64'd34);
    chk("b2b_second_acc",  64'(bus2.acc_real), 64'h0400_0000);
    repeat (10) step();

    // Abort at addr=10
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    found = 1'b0;
    for (int e = 0; e < 40 && !found; e++) begin
      if (bus2.addr_vld && bus2.addr == 5'd10) found = 1'b1;
      else step();
    end
    chk("abort_reach_10", 64'(found), 64'd1);
    abort_s = 1'b1;
    step();
    abort_s = 1'b0;
    chk("abort_vld",      64'(bus2.addr_vld), 64'd0);
    chk("abort_busy",     64'(bus2.busy),     64'd0);
    chk("abort_addr",     64'(bus2.addr),     64'd0);
    chk("abort_acc_real", 64'(bus2.acc_real), 64'd0);
    chk("abort_acc_imag", 64'(bus2.acc_imag), 64'd0);
    cnt = 0;
    for (int e = 0; e < 50; e++) begin
      if (bus2.done || bus4.done || bus2.addr_vld) cnt++;
      step();
    end
    chk("abort_no_done", 64'(cnt), 64'd0);
    run_check("post_abort", 0, 1'b0, 37'h00_0400_0000, 37'h1F_FE00_0000);

    // Abort and start together in IDLE
    start_s = 1'b1; abort_s = 1'b1;
    step();
    start_s = 1'b0; abort_s = 1'b0;
    chk("abst_busy", 64'(bus2.busy), 64'd0);
    chk("abst_vld",  64'(bus2.addr_vld), 64'd0);
    repeat (3) step();
    chk("abst_stays_idle", 64'(bus2.busy | bus4.busy), 64'd0);

    // Asynchronous reset mid-DRAIN
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    repeat (33) step();
    chk("pre_rst_busy", 64'(bus2.busy), 64'd1);
    chk("pre_rst_vld",  64'(bus2.addr_vld), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",     64'(bus2.busy),     64'd0);
    chk("arst_done",     64'(bus2.done),     64'd0);
    chk("arst_addr",     64'(bus2.addr),     64'd0);
    chk("arst_acc_real", 64'(bus2.acc_real), 64'd0);
    chk("arst_acc_imag", 64'(bus2.acc_imag), 64'd0);
    chk("arst_busy_l4",  64'(bus4.busy),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      if (bus2.done || bus4.done || bus2.addr_vld || bus4.addr_vld) cnt++;
      step();
    end
    chk("arst_no_spurious", 64'(cnt), 64'd0);
    run_check("post_rst", 0, 1'b0, 37'h00_0400_0000, 37'h1F_FE00_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
